// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin arbiter/controller that lets NCORES cores share
// one single-port synchronous RAM with a req/grant/done handshake.
//
// Build option: define ARB_PRIO0_EN to give core 0 fixed top priority.
// The other cores still rotate among themselves. Default build: pure round-robin.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | RAM free; arbitrate among requesting cores
// ST_ISSUE | one cycle driving the RAM (write commits at the next edge)
// ST_WAIT  | read in flight; count down RD_LAT edges, then capture ram_q
// ST_DONE  | one-cycle done pulse; no arbitration in this cycle

module mem_arbiter_rr #(
   parameter int NCORES = 4,
   parameter int DW     = 8,
   parameter int AW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCORES-1:0]    req,
   input  logic [NCORES-1:0]    wren,
   input  logic [NCORES*AW-1:0] addr,
   input  logic [NCORES*DW-1:0] din,
   output logic [NCORES-1:0]    grant,
   output logic [NCORES-1:0]    done,
   output logic [NCORES*DW-1:0] dq,
   output logic [AW-1:0]        ram_addr,
   output logic [DW-1:0]        ram_din,
   output logic                 ram_wren,
   input  logic [DW-1:0]        ram_q
);

   localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
   localparam int CW = $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t               state, state_nxt;
   logic [PW-1:0]        ptr, ptr_nxt;
   logic [PW-1:0]        owner, owner_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;
   logic [NCORES-1:0]    grant_nxt, done_nxt;
   logic [NCORES*DW-1:0] dq_nxt;
   logic [AW-1:0]        ram_addr_nxt;
   logic [DW-1:0]        ram_din_nxt;
   logic                 ram_wren_nxt;

   logic [PW-1:0]        win;
   logic                 win_vld;
   logic [PW:0]          scan_idx;

   // Winner search: first requester scanning ptr, ptr+1, ... modulo NCORES.
   // scan_idx has one spare bit so ptr+k never wraps before the modulo fixup.
   always_comb begin
      win      = '0;
      win_vld  = 1'b0;
      scan_idx = '0;
      for (int k = 0; k < NCORES; k++) begin
         scan_idx = {1'b0, ptr} + (PW+1)'(k);
         if (scan_idx >= (PW+1)'(NCORES)) begin
            scan_idx = scan_idx - (PW+1)'(NCORES);
         end
         if (!win_vld && req[scan_idx[PW-1:0]]) begin
            win     = scan_idx[PW-1:0];
            win_vld = 1'b1;
         end
      end
`ifdef ARB_PRIO0_EN
      if (req[0]) begin
         win     = '0;
         win_vld = 1'b1;
      end
`endif
   end

   // Next-state and registered-output logic; every register holds by default,
   // except done and ram_wren which are single-cycle pulses.
   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      owner_nxt    = owner;
      cnt_nxt      = cnt;
      grant_nxt    = grant;
      done_nxt     = '0;
      dq_nxt       = dq;
      ram_addr_nxt = ram_addr;
      ram_din_nxt  = ram_din;
      ram_wren_nxt = 1'b0;

      case (state)
         ST_IDLE: begin
            if (win_vld) begin
               owner_nxt    = win;
               grant_nxt    = {{(NCORES-1){1'b0}}, 1'b1} << win;
               ram_addr_nxt = addr[win*AW +: AW];
               ram_din_nxt  = din[win*DW +: DW];
               ram_wren_nxt = wren[win];
               ptr_nxt      = (win == PW'(NCORES-1)) ? '0 : win + 1'b1;
`ifdef ARB_PRIO0_EN
               // A core-0 win is out of band and must not disturb the rotation.
               if (win == '0) begin
                  ptr_nxt = ptr;
               end
`endif
               state_nxt    = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            // ram_wren still holds the captured write select of the owner.
            if (ram_wren) begin
               grant_nxt       = '0;
               done_nxt[owner] = 1'b1;
               state_nxt       = ST_DONE;
            end else begin
               cnt_nxt   = CW'(RD_LAT - 1);
               state_nxt = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (cnt == '0) begin
               dq_nxt[owner*DW +: DW] = ram_q;
               grant_nxt              = '0;
               done_nxt[owner]        = 1'b1;
               state_nxt              = ST_DONE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end

         ST_DONE: begin
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         owner    <= '0;
         cnt      <= '0;
         grant    <= '0;
         done     <= '0;
         dq       <= '0;
         ram_addr <= '0;
         ram_din  <= '0;
         ram_wren <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         owner    <= owner_nxt;
         cnt      <= cnt_nxt;
         grant    <= grant_nxt;
         done     <= done_nxt;
         dq       <= dq_nxt;
         ram_addr <= ram_addr_nxt;
         ram_din  <= ram_din_nxt;
         ram_wren <= ram_wren_nxt;
      end
   end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Testbench for mem_arbiter_rr: directed scenarios plus randomized traffic,
// checked each cycle against a transaction-level reference model.

module tb_mem_arbiter_rr;

   localparam int NCORES = 4;
   localparam int DW     = 8;
   localparam int AW     = 8;
   localparam int RD_LAT = 1;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NCORES-1:0]    req = '0;
   logic [NCORES-1:0]    wren = '0;
   logic [NCORES*AW-1:0] addr = '0;
   logic [NCORES*DW-1:0] din = '0;
   logic [NCORES-1:0]    grant;
   logic [NCORES-1:0]    done;
   logic [NCORES*DW-1:0] dq;
   logic [AW-1:0]        ram_addr;
   logic [DW-1:0]        ram_din;
   logic                 ram_wren;
   logic [DW-1:0]        ram_q;

   mem_arbiter_rr #(.NCORES(NCORES), .DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .wren(wren), .addr(addr), .din(din),
      .grant(grant), .done(done), .dq(dq), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_wren(ram_wren), .ram_q(ram_q)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM with RD_LAT output stages.
   logic          ram_clr = 1'b0;
   logic [DW-1:0] mem  [2**AW];
   logic [DW-1:0] pipe [RD_LAT];

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      end else if (ram_wren) begin
         mem[ram_addr] <= ram_din;
      end
      pipe[0] <= mem[ram_addr];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign ram_q = pipe[RD_LAT-1];

   // Scoreboard counters
   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // Reference model: a transaction occupies the RAM from its arbitration edge
   // to its done edge, and the next arbitration is two edges after done.
   logic [DW-1:0]        mem_m [2**AW];
   int                   m_ptr, m_busy, m_done_e, m_free_e, m_w, m_wr, m_addr, cyc;
   logic [NCORES-1:0]    exp_grant, exp_done;
   logic [NCORES*DW-1:0] exp_dq;
   logic [AW-1:0]        exp_addr;
   logic [DW-1:0]        exp_din;
   logic                 exp_wren;

   // Grants observed on the DUT, in order of rising grant
   int                   glog[$];
   logic [NCORES-1:0]    prev_grant;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NCORES-1:0] r);
      int j;
`ifdef ARB_PRIO0_EN
      if (r[0]) return 0;
`endif
      for (int k = 0; k < NCORES; k++) begin
         j = (m_ptr + k) % NCORES;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_busy = 0; m_done_e = -1; m_free_e = 0;
      m_w = 0; m_wr = 0; m_addr = 0;
      exp_grant = '0; exp_done = '0; exp_dq = '0;
      exp_addr = '0; exp_din = '0; exp_wren = 1'b0;
      prev_grant = '0;
   endtask

   task automatic model_edge();
      exp_done = '0;
      exp_wren = 1'b0;
      if (m_busy != 0 && cyc == m_done_e) begin
         exp_done[m_w] = 1'b1;
         exp_grant     = '0;
         if (m_wr == 0) exp_dq[m_w*DW +: DW] = mem_m[m_addr];
         m_busy = 0;
      end else if (m_busy == 0 && cyc >= m_free_e && req != '0) begin
         m_w       = pick(req);
         m_wr      = int'(wren[m_w]);
         m_addr    = int'(addr[m_w*AW +: AW]);
         exp_grant = '0;
         exp_grant[m_w] = 1'b1;
         exp_addr  = addr[m_w*AW +: AW];
         exp_din   = din[m_w*DW +: DW];
         exp_wren  = wren[m_w];
         if (m_wr != 0) mem_m[m_addr] = din[m_w*DW +: DW];
         m_done_e  = cyc + ((m_wr != 0) ? 1 : 1 + RD_LAT);
         m_free_e  = m_done_e + 2;
         m_busy    = 1;
`ifdef ARB_PRIO0_EN
         if (m_w != 0) m_ptr = (m_w + 1) % NCORES;
`else
         m_ptr = (m_w + 1) % NCORES;
`endif
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".grant"},    64'(grant),    64'(exp_grant));
      chk({tag, ".done"},     64'(done),     64'(exp_done));
      chk({tag, ".ram_wren"}, 64'(ram_wren), 64'(exp_wren));
      chk({tag, ".ram_addr"}, 64'(ram_addr), 64'(exp_addr));
      chk({tag, ".ram_din"},  64'(ram_din),  64'(exp_din));
      chk({tag, ".dq"},       64'(dq),       64'(exp_dq));
      chk({tag, ".grant_1h"}, 64'($onehot0(grant)), 64'(1));
      chk({tag, ".done_1h"},  64'($onehot0(done)),  64'(1));
   endtask

   // One clock edge: advance the model, then sample the DUT 1 time unit later.
   task automatic tick(input string tag);
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check_all(tag);
      if (grant != '0 && prev_grant == '0) begin
         for (int i = 0; i < NCORES; i++) if (grant[i]) glog.push_back(i);
      end
      prev_grant = grant;
   endtask

   task automatic ticks(input string tag, input int n);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   // Reset asserted away from the clock edge; outputs must clear at once.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, ".rst_grant"}, 64'(grant),    64'(0));
      chk({tag, ".rst_done"},  64'(done),     64'(0));
      chk({tag, ".rst_wren"},  64'(ram_wren), 64'(0));
      chk({tag, ".rst_addr"},  64'(ram_addr), 64'(0));
      chk({tag, ".rst_din"},   64'(ram_din),  64'(0));
      chk({tag, ".rst_dq"},    64'(dq),       64'(0));
      @(posedge clk);
      #1;
      chk({tag, ".rst_hold_done"}, 64'(done), 64'(0));
      model_reset();
      #2;
      rst_n = 1'b1;
   endtask

   task automatic set_core(input int i, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      req[i]            = r;
      wren[i]           = w;
      addr[i*AW +: AW]  = a;
      din[i*DW +: DW]   = d;
   endtask

   task automatic drop_all();
      req  = '0;
      wren = '0;
   endtask

   initial begin
      cyc = 0;
      for (int i = 0; i < 2**AW; i++) mem_m[i] = '0;
      model_reset();

      // Reset, RAM cleared during the first reset edge
      ram_clr = 1'b1;
      do_reset("init");
      ram_clr = 1'b0;

      // Single write from core 2
      set_core(2, 1'b1, 1'b1, 8'h10, 8'hA5);
      tick("wr_e0");
      chk("wr_grant",    64'(grant),    64'h4);
      chk("wr_ram_wren", 64'(ram_wren), 64'h1);
      chk("wr_ram_addr", 64'(ram_addr), 64'h10);
      chk("wr_ram_din",  64'(ram_din),  64'hA5);
      tick("wr_e1");
      chk("wr_done", 64'(done),  64'h4);
      chk("wr_gnt0", 64'(grant), 64'h0);
      drop_all();
      ticks("wr_tail", 2);

      // Readback from core 1
      set_core(1, 1'b1, 1'b0, 8'h10, 8'h00);
      tick("rd_e0");
      chk("rd_grant", 64'(grant), 64'h2);
      tick("rd_e1");
      chk("rd_no_done", 64'(done), 64'h0);
      tick("rd_e2");
      chk("rd_done", 64'(done), 64'h2);
      chk("rd_dq",   64'(dq),   64'h0000_A500);
      drop_all();
      ticks("rd_tail", 2);

      // All four cores reading continuously from ptr=0
      do_reset("rr");
      for (int i = 0; i < NCORES; i++) set_core(i, 1'b1, 1'b0, AW'($urandom_range(0, 31)), '0);
      glog.delete();
      ticks("rr", 20);
      chk("rr_count", 64'(glog.size() >= 5), 64'(1));
`ifdef ARB_PRIO0_EN
      for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 64'(glog[i]), 64'(0));
`else
      for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 64'(glog[i]), 64'(i % NCORES));
`endif
      drop_all();
      ticks("rr_drain", 6);

      // Core 3 drops req after grant; access still completes
      do_reset("drop");
      set_core(3, 1'b1, 1'b0, 8'h10, '0);
      tick("drop_e0");
      chk("drop_grant", 64'(grant), 64'h8);
      req[3] = 1'b0;
      set_core(0, 1'b1, 1'b0, 8'h03, '0);
      set_core(1, 1'b1, 1'b0, 8'h04, '0);
      tick("drop_e1");
      tick("drop_e2");
      chk("drop_done", 64'(done), 64'h8);
      tick("drop_e3");
      tick("drop_e4");
      chk("drop_next", 64'(grant), 64'h1);
      drop_all();
      ticks("drop_drain", 6);

      // Reset while a read is in WAIT
      do_reset("abort");
      set_core(2, 1'b1, 1'b0, 8'h10, '0);
      tick("abort_e0");
      tick("abort_e1");
      do_reset("abort");
      drop_all();
      set_core(1, 1'b1, 1'b0, 8'h10, '0);
      tick("abort_new");
      chk("abort_new_grant", 64'(grant), 64'h2);
      drop_all();
      ticks("abort_drain", 6);

      // Cores 0 and 2 requesting continuously
      do_reset("prio");
      set_core(0, 1'b1, 1'b0, 8'h01, '0);
      set_core(2, 1'b1, 1'b0, 8'h02, '0);
      glog.delete();
      ticks("prio", 16);
      chk("prio_count", 64'(glog.size() >= 4), 64'(1));
`ifdef ARB_PRIO0_EN
      for (int i = 0; i < 4; i++) chk($sformatf("prio_order%0d", i), 64'(glog[i]), 64'(0));
`else
      for (int i = 0; i < 4; i++) chk($sformatf("prio_order%0d", i), 64'(glog[i]), 64'((i % 2) * 2));
`endif
      req[0] = 1'b0;
      glog.delete();
      ticks("prio_drop0", 8);
      chk("prio_after_count", 64'(glog.size() >= 1), 64'(1));
      chk("prio_after", 64'(glog[0]), 64'(2));
      drop_all();
      ticks("prio_drain", 6);

      // Randomized traffic against the model
      do_reset("rand");
      for (int n = 0; n < 1500; n++) begin
         req  = NCORES'($urandom_range(0, 2**NCORES - 1));
         wren = NCORES'($urandom_range(0, 2**NCORES - 1));
         for (int i = 0; i < NCORES; i++) begin
            addr[i*AW +: AW] = AW'($urandom_range(0, 15));
            din[i*DW +: DW]  = DW'($urandom);
         end
         tick("rand");
      end
      drop_all();
      ticks("rand_drain", 6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
